// File: rtl/calc_op_sequencer.sv
// Sequences one calculator operation between the HPS and the ALU datapath.
// Optional WAIT-state timeout is enabled by defining CALC_TIMEOUT_EN.
module calc_op_sequencer #(
  parameter int DATA_W      = 16,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] op_in,
  output logic              busy,
  output logic              alu_start,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_op,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_error,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] status,
  output logic              snap_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_REPORT, S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic              timeout_hit;
  logic [DATA_W-1:0] cap_res;
  logic              cap_err;
  logic              cap_to;
  logic              done_q;
  logic              err_q;
  logic              to_q;
  logic [CNT_W-1:0]  op_cnt;

`ifdef CALC_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [TW-1:0] wait_cnt;

  // Counter restarts in ISSUE so every WAIT visit begins at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // Without the timeout the limit has no meaning; keep the parameter referenced.
  localparam int timeout_cyc_unused = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: next state gets a default first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (req) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT:    if (alu_done || timeout_hit) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_REPORT;
      S_REPORT:  state_nxt = S_HOLD;
      S_HOLD:    if (!req) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      cap_res <= '0;
      cap_err <= 1'b0;
      cap_to  <= 1'b0;
      result  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      op_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            alu_a  <= a_in;
            alu_b  <= b_in;
            alu_op <= op_in;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            to_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          // A real completion on the same edge as the timeout takes priority.
          if (alu_done) begin
            cap_res <= alu_result;
            cap_err <= alu_error;
            cap_to  <= 1'b0;
          end else if (timeout_hit) begin
            cap_res <= '0;
            cap_err <= 1'b1;
            cap_to  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          result <= cap_err ? '0 : cap_res;
          done_q <= 1'b1;
          err_q  <= cap_err;
          to_q   <= cap_to;
          op_cnt <= op_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    status             = '0;
    status[0]          = done_q;
    status[1]          = err_q;
    status[2]          = to_q;
    status[8 +: CNT_W] = op_cnt;
  end

  assign busy      = (state == S_ISSUE) || (state == S_WAIT) ||
                     (state == S_CAPTURE) || (state == S_REPORT);
  assign alu_start = (state == S_ISSUE);
  assign snap_we   = (state == S_REPORT);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed, table-driven bench for calc_op_sequencer; the timeout scenario
// runs only when CALC_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYC=8).
module tb_calc_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [15:0] a_in = '0, b_in = '0, op_in = '0;
  logic        busy, alu_start, snap_we;
  logic [15:0] alu_a, alu_b, alu_op, result, status;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        alu_error = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int snap_cnt  = 0;
  int exp_cnt   = 0;

  calc_op_sequencer #(.DATA_W(16), .CNT_W(8), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .busy(busy), .alu_start(alu_start),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .alu_error(alu_error),
    .result(result), .status(status), .snap_we(snap_we)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, one sample per clock.
  always @(negedge clk) begin
    if (alu_start) start_cnt <= start_cnt + 1;
    if (snap_we)   snap_cnt  <= snap_cnt + 1;
  end

  typedef struct {
    logic [15:0] a, b, op, res;
    logic        err;
    int          lat;
    bit          early;
    bit          poke;
    logic [15:0] exp_result;
    logic [15:0] exp_status;
  } vec_t;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int s0, w0, n;
    s0 = start_cnt;
    w0 = snap_cnt;
    a_in = v.a; b_in = v.b; op_in = v.op; req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!alu_start && n < 8);
    check({tag, "/start_lat"}, n, 1);
    check({tag, "/busy_issue"}, busy, 1);
    for (int i = 0; i < v.lat; i++) begin
      if (i == 0 && v.early) begin
        alu_done = 1'b1; alu_result = 16'hDEAD; alu_error = 1'b1;
      end
      tick();
      alu_done = 1'b0; alu_error = 1'b0;
      if (v.poke && i == 0) begin a_in = 16'hFFFF; req = 1'b0; end
      if (v.poke && i == 1) req = 1'b1;
    end
    alu_done = 1'b1; alu_result = v.res; alu_error = v.err;
    tick();
    alu_done = 1'b0; alu_error = 1'b0; alu_result = 16'hBEEF;
    check({tag, "/snap_capture"}, snap_we, 0);
    tick();
    check({tag, "/snap_report"}, snap_we, 1);
    check({tag, "/result"}, result, v.exp_result);
    check({tag, "/status"}, status, v.exp_status);
    check({tag, "/alu_a"}, alu_a, v.a);
    check({tag, "/alu_b"}, alu_b, v.b);
    check({tag, "/alu_op"}, alu_op, v.op);
    tick();
    tick();
    check({tag, "/busy_hold"}, busy, 0);
    check({tag, "/n_start"}, start_cnt - s0, 1);
    check({tag, "/n_snap"}, snap_cnt - w0, 1);
    req = 1'b0;
    tick();
  endtask

  vec_t vecs[5];

  initial begin
    int s0, w0, n;
    vec_t v;

    vecs[0] = '{16'h0003, 16'h0004, 16'h0001, 16'h0007, 1'b0, 3, 1'b0, 1'b0, 16'h0007, 16'h0101};
    vecs[1] = '{16'h0010, 16'h0000, 16'h0004, 16'h1234, 1'b1, 2, 1'b0, 1'b0, 16'h0000, 16'h0203};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1, 1'b0, 1'b0, 16'h0000, 16'h0301};
    vecs[3] = '{16'h0005, 16'h0006, 16'h0002, 16'h001E, 1'b0, 4, 1'b0, 1'b1, 16'h001E, 16'h0401};
    vecs[4] = '{16'h00AA, 16'h0055, 16'h0003, 16'h00FF, 1'b0, 5, 1'b1, 1'b0, 16'h00FF, 16'h0501};

    // Reset held for two cycles, then released with req low.
    tick(); tick();
    rst = 1'b1;
    s0 = start_cnt;
    tick();
    check("rst/busy", busy, 0);
    check("rst/alu_start", alu_start, 0);
    check("rst/snap_we", snap_we, 0);
    check("rst/result", result, 0);
    check("rst/status", status, 0);
    check("rst/alu_a", alu_a, 0);
    tick(); tick();
    check("rst/no_start", start_cnt - s0, 0);

    for (int k = 0; k < 5; k++) begin
      run_op(vecs[k], $sformatf("vec%0d", k));
    end
    exp_cnt = 5;

`ifdef CALC_TIMEOUT_EN
    // ISSUE, eight WAIT cycles, CAPTURE, then REPORT ten cycles after ISSUE.
    a_in = 16'h0009; b_in = 16'h0002; op_in = 16'h0004; req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!alu_start && n < 8);
    check("to/start_lat", n, 1);
    n = 0;
    do begin tick(); n++; end while (!snap_we && n < 40);
    check("to/report_lat", n, 10);
    check("to/result", result, 0);
    check("to/status", status, 16'h0607);
    req = 1'b0;
    tick(); tick();
    exp_cnt = 6;
`endif

    // Reset during WAIT abandons the op; a later alu_done must be ignored.
    s0 = start_cnt;
    w0 = snap_cnt;
    a_in = 16'h0101; b_in = 16'h0202; op_in = 16'h0001; req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!alu_start && n < 8);
    check("rstw/start_lat", n, 1);
    tick();
    rst = 1'b0; req = 1'b0;
    tick();
    rst = 1'b1;
    alu_done = 1'b1; alu_result = 16'h5555;
    tick();
    alu_done = 1'b0;
    repeat (4) tick();
    check("rstw/n_start", start_cnt - s0, 1);
    check("rstw/n_snap", snap_cnt - w0, 0);
    check("rstw/status", status, 0);
    check("rstw/result", result, 0);
    check("rstw/busy", busy, 0);
    check("rstw/alu_a", alu_a, 0);
    exp_cnt = 0;

    // 256 minimum-latency ops: the count walks up to 0xFF then wraps to 0x00.
    for (int i = 0; i < 256; i++) begin
      exp_cnt = (exp_cnt + 1) % 256;
      v.a = 16'(i); v.b = 16'(2 * i); v.op = 16'h0001;
      v.res = 16'(3 * i); v.err = 1'b0; v.lat = 1;
      v.early = 1'b0; v.poke = 1'b0;
      v.exp_result = 16'(3 * i);
      v.exp_status = {8'(exp_cnt), 8'h01};
      run_op(v, $sformatf("wrap%0d", i));
      if (i == 254) check("wrap/at_ff", status[15:8], 8'hFF);
    end
    check("wrap/to_zero", status[15:8], 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
